// File: rtl/parity_serial_tx.sv
// rtl/parity_serial_tx.sv - byte serializer: start, 8 data bits LSB first, parity, stop
module parity_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       load,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       parity_out
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);
  localparam logic       PAR_INV  = (ODD_PARITY != 0);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] shreg_q;
  logic       tx_q;
  logic       busy_q;
  logic       done_q;
  logic       ready_q;
  logic       parity_q;
  logic       bit_end;

  assign bit_end = (cnt_q == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      parity_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) cnt_q <= bit_end ? 8'd0 : cnt_q + 8'd1;
      case (state_q)
        IDLE: begin
          if (load) begin
            shreg_q  <= data_in;
            parity_q <= (^data_in) ^ PAR_INV;
            cnt_q    <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_q    <= shreg_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          // shreg_q[0] is the bit on the line; shift so the next one moves into place
          if (bit_end) begin
            if (bit_q == 3'd7) begin
              tx_q    <= parity_q;
              state_q <= PARITY;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shreg_q <= {1'b0, shreg_q[7:1]};
              tx_q    <= shreg_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ready      = ready_q;
  assign parity_out = parity_q;

endmodule
